// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed 4-digit hex scanner with dead time between digits
// and leading-zero blanking; all display data comes from a snapshot register.
module seven_seg_scan_ctrl #(
    parameter int CLK_DIV  = 50000,
    parameter int DEAD_CYC = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_En,
    input  logic        i_Load,
    input  logic [15:0] i_Value,
    input  logic        i_Lzb,
    output logic [3:0]  o_Nibble,
    output logic [3:0]  o_Anode_n,
    output logic        o_Frame
);
    localparam int MAXC = (CLK_DIV > DEAD_CYC) ? CLK_DIV : DEAD_CYC;
    localparam int CW   = $clog2(MAXC);

    typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx, idx_nxt;
    logic [15:0]     snap;
    logic            blank;
    logic            dead_done, drive_done, dead_entry;

    assign dead_done  = (state == DEAD) && (cnt == CW'(DEAD_CYC - 1));
    assign drive_done = (state == DRIVE) && (cnt == CW'(CLK_DIV - 1));
    assign dead_entry = i_En && ((state == IDLE) || drive_done);
    assign idx_nxt    = (state == IDLE) ? 2'd0 : idx + 2'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = !i_En ? IDLE :
                    (state == IDLE) ? DEAD :
                    dead_done ? DRIVE :
                    drive_done ? DEAD : state;
    end

    // Slot data (digit, blanking) is latched at DEAD entry from the pre-load snap.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt      <= '0;
            idx      <= 2'd0;
            snap     <= 16'h0000;
            o_Nibble <= 4'h0;
            blank    <= 1'b0;
        end else begin
            if (i_Load)
                snap <= i_Value;
            if (!i_En) begin
                cnt <= '0;
                idx <= 2'd0;
            end else begin
                cnt <= ((state == IDLE) || dead_done || drive_done) ? '0 : cnt + 1'b1;
                if (dead_entry) begin
                    idx      <= idx_nxt;
                    o_Nibble <= snap[{idx_nxt, 2'b00} +: 4];
                    blank    <= i_Lzb && (idx_nxt != 2'd0) && ((snap >> {idx_nxt, 2'b00}) == 16'h0000);
                end
            end
        end
    end

    always_comb begin
        o_Anode_n = ((state == DRIVE) && !blank) ? ~(4'b0001 << idx) : 4'b1111;
        o_Frame   = (state == DEAD) && (cnt == '0) && (idx == 2'd0);
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed and random scan checks against a time-since-enable
// reference model (slot = t / (DEAD+DIV), digit = slot mod 4, phase = t mod slot length).
module tb_seven_seg_scan_ctrl;
    localparam int DIV  = 8;
    localparam int DC   = 2;
    localparam int SLOT = DIV + DC;

    logic        clk = 1'b0;
    logic        rst_n, en, load, lzb;
    logic [15:0] value;
    logic [3:0]  nibble, anode_n;
    logic        frame;

    int          vectors = 0;
    int          miscmp  = 0;

    int          m_t;
    int          m_dig;
    logic [15:0] m_snap;
    logic [3:0]  m_nib;
    logic        m_blank;

    seven_seg_scan_ctrl #(.CLK_DIV(DIV), .DEAD_CYC(DC)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en), .i_Load(load), .i_Value(value),
        .i_Lzb(lzb), .o_Nibble(nibble), .o_Anode_n(anode_n), .o_Frame(frame)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_t = -1; m_dig = 0; m_snap = 16'h0; m_nib = 4'h0; m_blank = 1'b0;
    endtask

    task automatic step();
        if (!rst_n) begin
            m_reset();
        end else begin
            if (!en) m_t = -1;
            else begin
                m_t++;
                if (m_t % SLOT == 0) begin
                    m_dig   = (m_t / SLOT) % 4;
                    m_nib   = 4'((m_snap >> (4 * m_dig)) & 16'hF);
                    m_blank = lzb && m_dig != 0 && ((m_snap >> (4 * m_dig)) == 16'h0);
                end
            end
            if (load) m_snap = value;
        end
    endtask

    task automatic check();
        logic [3:0] ea;
        logic       ef;
        ea = (m_t < 0 || m_t % SLOT < DC || m_blank) ? 4'b1111 : ~(4'b0001 << m_dig);
        ef = (m_t >= 0) && (m_t % (4 * SLOT) == 0);
        vectors += 4;
        assert (anode_n === ea) else begin miscmp++; $error("FAIL anode t=%0d got %b exp %b", m_t, anode_n, ea); end
        assert (nibble === m_nib) else begin miscmp++; $error("FAIL nibble t=%0d got %h exp %h", m_t, nibble, m_nib); end
        assert (frame === ef) else begin miscmp++; $error("FAIL frame t=%0d got %b exp %b", m_t, frame, ef); end
        assert ($countones(~anode_n) <= 1) else begin miscmp++; $error("FAIL onehot t=%0d got %b exp <=1 low", m_t, anode_n); end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            step();
            #1;
            check();
        end
    endtask

    task automatic load_val(input logic [15:0] v);
        value = v; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; lzb = 1'b0; value = 16'h0;
        m_reset();
        #23;
        check();
        cyc(2);
        @(negedge clk); rst_n = 1'b1;
        // basic scan of 1234
        load_val(16'h1234);
        en = 1'b1;
        cyc(1);
        vectors++;
        assert (frame === 1'b1 && nibble === 4'h4) else begin miscmp++; $error("FAIL first_slot got frame=%b nib=%h exp frame=1 nib=4", frame, nibble); end
        cyc(79);
        // leading-zero blanking on and off
        en = 1'b0; cyc(1);
        load_val(16'h0050); lzb = 1'b1; en = 1'b1; cyc(40);
        en = 1'b0; cyc(1);
        lzb = 1'b0; en = 1'b1; cyc(40);
        en = 1'b0; cyc(1);
        load_val(16'h0000); lzb = 1'b1; en = 1'b1; cyc(40);
        // enable dropped mid-drive of digit 2
        en = 1'b0; cyc(1);
        lzb = 1'b0; load_val(16'h1234); en = 1'b1; cyc(25);
        en = 1'b0; cyc(1);
        vectors++;
        assert (anode_n === 4'b1111) else begin miscmp++; $error("FAIL en_drop got %b exp 1111", anode_n); end
        cyc(3);
        en = 1'b1; cyc(12);
        // load coinciding with digit-1 DEAD entry
        en = 1'b0; cyc(1);
        en = 1'b1; cyc(10);
        load_val(16'hABCD);
        vectors++;
        assert (nibble === 4'h3) else begin miscmp++; $error("FAIL old_snap got %h exp 3", nibble); end
        cyc(10);
        vectors++;
        assert (nibble === 4'hB) else begin miscmp++; $error("FAIL new_snap got %h exp b", nibble); end
        cyc(30);
        // asynchronous reset mid-drive
        cyc(4);
        #2; rst_n = 1'b0; #1;
        m_reset();
        check();
        cyc(2);
        @(negedge clk); rst_n = 1'b1;
        cyc(1);
        vectors++;
        assert (frame === 1'b1) else begin miscmp++; $error("FAIL resume_frame got %b exp 1", frame); end
        cyc(20);
        // random traffic
        for (int k = 0; k < 1500; k++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom >> ($urandom_range(0, 4) * 4 + 16));
            if ($urandom_range(0, 15) == 0) lzb = ~lzb;
            en = ($urandom_range(0, 99) != 0);
            cyc(1);
        end
        load = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001: The block SHALL have parameter CLK_DIV, default 50000, giving drive cycles per digit slot (legal range >=2).
REQ-002: The block SHALL have parameter DEAD_CYC, default 4, giving all-off cycles before each digit drive (legal range >=1).
REQ-003: The block SHALL have port i_Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004: The block SHALL have port i_Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005: The block SHALL have port i_En, input, 1 bit: scan enable.
REQ-006: The block SHALL have port i_Load, input, 1 bit: snapshot strobe for i_Value.
REQ-007: The block SHALL have port i_Value, input, 16 bits: four hex digits; digit k is bits [4k+3:4k].
REQ-008: The block SHALL have port i_Lzb, input, 1 bit: leading-zero blanking enable.
REQ-009: The block SHALL have port o_Nibble, output, 4 bits: the digit code for the shared registered hex decoder (1-cycle latency).
REQ-010: The block SHALL have port o_Anode_n, output, 4 bits: active-low digit enables, at most one low.
REQ-011: The block SHALL have port o_Frame, output, 1 bit: one-cycle pulse at the start of each digit-0 slot.

Function
REQ-012: Snapshot register snap SHALL load i_Value on any edge with i_Load=1; displayed data SHALL come only from snap.
REQ-013: FSM states SHALL be IDLE, DEAD and DRIVE; one counter cnt SHALL be shared, sized for max(CLK_DIV, DEAD_CYC).
REQ-014: IDLE: o_Anode_n=4'b1111, idx=0; when i_En=1, next state SHALL be DEAD with cnt=0.
REQ-015: DEAD entry: o_Nibble SHALL take snap digit idx on that edge and hold it for the whole slot; o_Anode_n=4'b1111 for exactly DEAD_CYC cycles.
REQ-016: DEAD to DRIVE SHALL occur when cnt=DEAD_CYC-1; cnt SHALL clear.
REQ-017: DRIVE: o_Anode_n[idx]=0 (others 1) for exactly CLK_DIV cycles unless the digit is blanked (REQ-019).
REQ-018: DRIVE end (cnt=CLK_DIV-1): idx SHALL go to idx+1 mod 4 (3 wraps to 0), state SHALL go to DEAD.
REQ-019: With i_Lzb=1, digit k>=1 SHALL be blanked when snap digits k..3 are all zero; blanking SHALL be evaluated at DEAD entry. Digit 0 SHALL never be blanked. Blanked digits keep o_Anode_n=4'b1111 but keep full slot timing.
REQ-020: o_Frame SHALL be 1 for exactly the first DEAD cycle of every idx=0 slot.
REQ-021: i_En=0 in any state SHALL force IDLE on the next edge: anodes off, idx=0, cnt=0; the partial slot is abandoned.
REQ-022: An i_Load coinciding with DEAD entry SHALL NOT affect that slot's o_Nibble (old snap is used); the new value SHALL apply from the next slot.
REQ-023: The full frame period SHALL be 4*(DEAD_CYC+CLK_DIV) cycles, with no idle cycles while i_En=1.

Reset
REQ-024: While i_Rst_n=0, regardless of clock: state=IDLE, idx=0, cnt=0, snap=16'h0000, o_Nibble=4'h0, o_Anode_n=4'b1111, o_Frame=0.
REQ-025: Reset deassertion mid-scan SHALL resume from IDLE; the first slot after i_En=1 SHALL be digit 0.

Verification (CLK_DIV=8, DEAD_CYC=2)
REQ-026: Reset, i_Load with i_Value=16'h1234, i_En=1 -> o_Frame pulse; nibbles 4,3,2,1 in order; anodes 1110,1101,1011,0111, each low 8 cycles after 2 off cycles; period 40 cycles.
REQ-027: i_Value=16'h0050, i_Lzb=1 -> digits 0 and 1 driven; digits 2 and 3 anodes stay 1111 for their full slots. With i_Lzb=0 -> all four digits driven.
REQ-028: i_Value=16'h0000, i_Lzb=1 -> only digit 0 driven, o_Nibble=0 in its slot.
REQ-029: i_En dropped mid-DRIVE of digit 2 -> next cycle anodes 1111; on re-enable the first slot is digit 0 with an o_Frame pulse.
REQ-030: i_Load of 16'hABCD on the DEAD-entry edge of digit 1 -> digit 1 shows the old snap; digit 2 shows B.
REQ-031: i_Rst_n asserted asynchronously mid-DRIVE -> outputs reach reset values without a clock edge; the one-hot-low anode check passes throughout.
